// File: rtl/usb_tx_ctrl_if.sv
// Upstream byte handshake between the Tx FIFO/packet builder and usb_tx_ctrl.
//   tx_start : one-cycle request to begin a packet (honoured only when idle)
//   tx_data  : payload byte, sent LSB first
//   tx_valid : tx_data/tx_last are valid
//   tx_last  : current byte is the final payload byte
//   tx_ready : one-cycle pulse, byte consumed at the coming clock edge
// master = byte source, slave = usb_tx_ctrl.
interface usb_tx_ctrl_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (
        output tx_start,
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/usb_tx_ctrl.sv
// USB Tx sequencer: emits SYNC, payload bytes and EOP as control strobes for
// the NRZI encode block, with bit timing and bit stuffing.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   tx            : upstream byte handshake (slave side); tx_ready is
//                   combinational and pulses in the cycle a byte is taken
//   d_orig        : raw bit to encode (0 = line transition), held per period
//   shift_enable  : one-cycle strobe at the start of each SYNC/DATA/STUFF bit
//   eop           : SE0 request during the EOP periods
//   eop_special   : forced-J request during the final bit period
//   sending       : line driven by the transmitter
//   busy          : sequencer is not idle
//   done          : one-cycle pulse in the first idle cycle after a packet
//   underrun      : combinational one-cycle pulse, byte needed but none valid
module usb_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'h80,
    parameter int unsigned EOP_BITS     = 2
) (
    input  logic          clk,
    input  logic          rst,
    usb_tx_ctrl_if.slave  tx,
    output logic          d_orig,
    output logic          shift_enable,
    output logic          eop,
    output logic          eop_special,
    output logic          sending,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    localparam int unsigned BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ECNT_W = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(EOP_BITS - 1);
    localparam int unsigned STUFF_RUN = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_STUFF,
        S_EOP,
        S_EOPJ
    } state_t;

    state_t            state;
    logic [BCNT_W-1:0] bcnt;        // clocks within the current bit period
    logic [ECNT_W-1:0] ecnt;        // SE0 bit periods already sent
    logic [7:0]        shreg;       // shreg[0] is the bit on the line
    logic [2:0]        bidx;        // index of the bit on the line
    logic [2:0]        ones;        // consecutive ones before the current bit
    logic              sync_phase;  // still sending SYNC (no payload loaded yet)
    logic              last_byte;   // byte being sent was flagged tx_last
    logic              byte_done;   // pending stuff bit follows bit 7

    logic       bit_end_c;
    logic       data_bit_c;
    logic [2:0] ones_nxt_c;
    logic       stuff_c;
    logic       load_pt_c;
    logic       want_byte_c;

    // Bit-period bookkeeping and the byte load point.
    always_comb begin
        bit_end_c   = 1'b0;
        data_bit_c  = 1'b0;
        ones_nxt_c  = 3'd0;
        stuff_c     = 1'b0;
        load_pt_c   = 1'b0;
        want_byte_c = 1'b0;

        bit_end_c   = (bcnt == BCNT_LAST);
        data_bit_c  = (state == S_SYNC) || (state == S_DATA);
        ones_nxt_c  = shreg[0] ? (ones + 3'd1) : 3'd0;
        stuff_c     = data_bit_c && (ones_nxt_c == 3'(STUFF_RUN));
        // A stuff bit after bit 7 pushes the load point to the end of STUFF.
        load_pt_c   = bit_end_c &&
                      ((data_bit_c && (bidx == 3'd7) && !stuff_c) ||
                       ((state == S_STUFF) && byte_done));
        // After the last payload byte no further byte is requested.
        want_byte_c = sync_phase || !last_byte;
    end

    // Handshake pulses are combinational so the byte is taken on this edge.
    always_comb begin
        tx.tx_ready = 1'b0;
        underrun    = 1'b0;
        if (load_pt_c && want_byte_c) begin
            tx.tx_ready = tx.tx_valid;
            underrun    = !tx.tx_valid;
        end
    end

    // Sequencer: state, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            bcnt         <= '0;
            ecnt         <= '0;
            shreg        <= '0;
            bidx         <= '0;
            ones         <= '0;
            sync_phase   <= 1'b0;
            last_byte    <= 1'b0;
            byte_done    <= 1'b0;
            d_orig       <= 1'b1;
            shift_enable <= 1'b0;
            eop          <= 1'b0;
            eop_special  <= 1'b0;
            sending      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            shift_enable <= 1'b0;
            done         <= 1'b0;

            if (state != S_IDLE) begin
                bcnt <= bit_end_c ? '0 : (bcnt + BCNT_W'(1));
            end

            case (state)
                S_IDLE: begin
                    if (tx.tx_start) begin
                        state        <= S_SYNC;
                        bcnt         <= '0;
                        shreg        <= SYNC_BYTE;
                        bidx         <= '0;
                        ones         <= '0;
                        sync_phase   <= 1'b1;
                        last_byte    <= 1'b0;
                        byte_done    <= 1'b0;
                        d_orig       <= SYNC_BYTE[0];
                        shift_enable <= 1'b1;
                        sending      <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                S_SYNC, S_DATA: begin
                    if (bit_end_c) begin
                        ones  <= stuff_c ? 3'd0 : ones_nxt_c;
                        shreg <= {1'b0, shreg[7:1]};
                        if (stuff_c) begin
                            // Bit index already moves past the sent bit; the
                            // stuff period itself does not consume one.
                            state        <= S_STUFF;
                            byte_done    <= (bidx == 3'd7);
                            bidx         <= bidx + 3'd1;
                            d_orig       <= 1'b0;
                            shift_enable <= 1'b1;
                        end else if (bidx != 3'd7) begin
                            bidx         <= bidx + 3'd1;
                            d_orig       <= shreg[1];
                            shift_enable <= 1'b1;
                        end
                    end
                end

                S_STUFF: begin
                    if (bit_end_c && !byte_done) begin
                        state        <= sync_phase ? S_SYNC : S_DATA;
                        d_orig       <= shreg[0];
                        shift_enable <= 1'b1;
                    end
                end

                S_EOP: begin
                    if (bit_end_c) begin
                        if (ecnt == ECNT_LAST) begin
                            state       <= S_EOPJ;
                            eop         <= 1'b0;
                            eop_special <= 1'b1;
                        end else begin
                            ecnt <= ecnt + ECNT_W'(1);
                        end
                    end
                end

                S_EOPJ: begin
                    if (bit_end_c) begin
                        state       <= S_IDLE;
                        eop_special <= 1'b0;
                        sending     <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        d_orig      <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Load point: take the next byte, or close the packet with EOP.
            if (load_pt_c) begin
                byte_done <= 1'b0;
                if (want_byte_c && tx.tx_valid) begin
                    state        <= S_DATA;
                    shreg        <= tx.tx_data;
                    last_byte    <= tx.tx_last;
                    sync_phase   <= 1'b0;
                    bidx         <= '0;
                    d_orig       <= tx.tx_data[0];
                    shift_enable <= 1'b1;
                end else begin
                    state  <= S_EOP;
                    ecnt   <= '0;
                    eop    <= 1'b1;
                    d_orig <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Self-checking bench for usb_tx_ctrl: directed and randomized packets
// compared against a bit-stream model (SYNC + payload, stuffing, EOP timing).
module tb_usb_tx_ctrl;

    localparam int unsigned CPB  = 8;
    localparam int unsigned EOPB = 2;
    localparam logic [7:0]  SYNC = 8'h80;

    logic clk = 1'b0;
    logic rst;
    logic d_orig, shift_enable, eop, eop_special, sending, busy, done, underrun;

    usb_tx_ctrl_if txif();

    usb_tx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (SYNC),
        .EOP_BITS     (EOPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx           (txif),
        .d_orig       (d_orig),
        .shift_enable (shift_enable),
        .eop          (eop),
        .eop_special  (eop_special),
        .sending      (sending),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Packet under test and the reference expectations.
    logic [7:0] pkt [8];
    bit         exp_bits [$];
    int         exp_ready [$];
    int         exp_under;

    // Observations.
    bit obs_bits [$];
    int obs_ready [$];
    int obs_under [$];
    int eop_first, eop_cnt, ej_first, ej_cnt, done_first, done_cnt;

    // Reference: raw stream (SYNC + bytes up to underrun), then stuffing
    // pass; every bit period is CPB cycles, cycle 1 is the first SYNC cycle.
    task automatic model(input int n, input int u);
        bit         raw [$];
        int         starts [$];
        logic [7:0] b;
        int         ones;
        int         k;
        exp_bits.delete();
        exp_ready.delete();
        exp_under = -1;
        b = SYNC;
        for (int i = 0; i < 8; i++) raw.push_back(b[i]);
        for (int j = 0; j < n && j < u; j++) begin
            starts.push_back(raw.size());
            b = pkt[j];
            for (int i = 0; i < 8; i++) raw.push_back(b[i]);
        end
        ones = 0;
        k = 0;
        for (int r = 0; r < raw.size(); r++) begin
            if (k < starts.size() && starts[k] == r) begin
                exp_ready.push_back(CPB * exp_bits.size());
                k++;
            end
            exp_bits.push_back(raw[r]);
            ones = raw[r] ? ones + 1 : 0;
            if (ones == 6) begin
                exp_bits.push_back(1'b0);
                ones = 0;
            end
        end
        if (u < n) exp_under = CPB * exp_bits.size();
    endtask

    task automatic drive(input int idx, input int n, input int u);
        txif.tx_valid = (idx < u);
        txif.tx_data  = (idx < n) ? pkt[idx] : 8'($urandom);
        txif.tx_last  = (idx == n - 1);
    endtask

    task automatic sample(input int c);
        if (shift_enable) obs_bits.push_back(d_orig);
        if (txif.tx_ready) obs_ready.push_back(c);
        if (underrun) obs_under.push_back(c);
        if (eop) begin
            if (eop_cnt == 0) eop_first = c;
            eop_cnt++;
        end
        if (eop_special) begin
            if (ej_cnt == 0) ej_first = c;
            ej_cnt++;
        end
        if (done) begin
            if (done_cnt == 0) done_first = c;
            done_cnt++;
        end
    endtask

    task automatic clear_obs();
        obs_bits.delete();
        obs_ready.delete();
        obs_under.delete();
        eop_first = -1; eop_cnt = 0;
        ej_first  = -1; ej_cnt  = 0;
        done_first = -1; done_cnt = 0;
    endtask

    // Run one packet of n bytes; valid drops at byte u (u == n: never).
    task automatic run_packet(input string name, input int n, input int u, input bit extra_start);
        int idx;
        bit rdy;
        int p;
        model(n, u);
        clear_obs();
        idx = 0;
        rdy = 1'b0;
        @(posedge clk); #1;
        txif.tx_start = 1'b1;
        drive(idx, n, u);
        for (int c = 1; c < 3000; c++) begin
            @(posedge clk); #1;
            if (rdy) idx++;
            txif.tx_start = extra_start && (c == 10 || c == 100);
            drive(idx, n, u);
            @(negedge clk);
            rdy = txif.tx_ready;
            sample(c);
            if (done_cnt > 0 && c >= done_first + 20) break;
        end
        txif.tx_start = 1'b0;
        txif.tx_valid = 1'b0;

        p = exp_bits.size();
        check({name, " strobes"}, obs_bits.size(), exp_bits.size());
        for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++)
            check($sformatf("%s bit%0d", name, i), 32'(obs_bits[i]), 32'(exp_bits[i]));
        check({name, " ready_cnt"}, obs_ready.size(), exp_ready.size());
        for (int i = 0; i < obs_ready.size() && i < exp_ready.size(); i++)
            check($sformatf("%s ready%0d", name, i), obs_ready[i], exp_ready[i]);
        check({name, " underrun_cnt"}, obs_under.size(), (exp_under < 0) ? 0 : 1);
        if (exp_under >= 0 && obs_under.size() > 0)
            check({name, " underrun_cyc"}, obs_under[0], exp_under);
        check({name, " eop_first"}, eop_first, CPB * p + 1);
        check({name, " eop_len"}, eop_cnt, CPB * EOPB);
        check({name, " eopj_first"}, ej_first, CPB * (p + EOPB) + 1);
        check({name, " eopj_len"}, ej_cnt, CPB);
        check({name, " done_cyc"}, done_first, CPB * (p + EOPB + 1) + 1);
        check({name, " done_cnt"}, done_cnt, 1);
        check({name, " idle_busy"}, 32'(busy), 0);
        check({name, " idle_sending"}, 32'(sending), 0);
    endtask

    initial begin
        int n, u, sel;

        rst = 1'b1;
        txif.tx_start = 1'b0;
        txif.tx_data  = 8'h00;
        txif.tx_valid = 1'b0;
        txif.tx_last  = 1'b0;
        #1;
        check("rst d_orig", 32'(d_orig), 1);
        check("rst shift_enable", 32'(shift_enable), 0);
        check("rst sending", 32'(sending), 0);
        check("rst busy", 32'(busy), 0);
        check("rst eop", 32'(eop), 0);
        check("rst eop_special", 32'(eop_special), 0);
        check("rst done", 32'(done), 0);
        check("rst underrun", 32'(underrun), 0);
        check("rst tx_ready", 32'(txif.tx_ready), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single 0x00 byte: fixed cycle numbers cross-check the model.
        pkt[0] = 8'h00;
        run_packet("s1", 1, 1, 1'b0);
        if (obs_ready.size() > 0) check("s1 ready_abs", obs_ready[0], 64);
        check("s1 done_abs", done_first, 153);

        pkt[0] = 8'hFF;
        run_packet("s2", 1, 1, 1'b0);
        check("s2 done_abs", done_first, 161);

        pkt[0] = 8'h3F; pkt[1] = 8'h01;
        run_packet("s3", 2, 2, 1'b0);

        pkt[0] = 8'h12;
        run_packet("s4", 1, 0, 1'b0);
        check("s4 done_abs", done_first, 89);

        // Reset mid-SYNC, then a clean packet.
        clear_obs();
        pkt[0] = 8'hA5;
        @(posedge clk); #1;
        txif.tx_start = 1'b1;
        drive(0, 1, 1);
        for (int c = 1; c < 40; c++) begin
            @(posedge clk); #1;
            txif.tx_start = 1'b0;
            @(negedge clk);
            sample(c);
        end
        check("s5 busy_before", 32'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("s5 sending", 32'(sending), 0);
        check("s5 shift_enable", 32'(shift_enable), 0);
        check("s5 busy", 32'(busy), 0);
        check("s5 d_orig", 32'(d_orig), 1);
        check("s5 eop", 32'(eop), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sample(100 + c);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sample(200 + c);
        end
        check("s5 no_done", done_cnt, 0);
        pkt[0] = 8'h5A;
        run_packet("s5b", 1, 1, 1'b0);

        // tx_start pulses while busy are ignored.
        pkt[0] = 8'hC3;
        run_packet("s6", 1, 1, 1'b1);

        // Trailing stuff after the last byte; stuff at a mid-packet load point.
        pkt[0] = 8'h00; pkt[1] = 8'hFC;
        run_packet("s7", 2, 2, 1'b0);
        pkt[0] = 8'hFC; pkt[1] = 8'h00;
        run_packet("s8", 2, 2, 1'b0);

        // Randomized packets, stuff-prone bytes favoured.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                sel = $urandom_range(0, 3);
                pkt[i] = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h3F :
                         (sel == 2) ? 8'hFC : 8'($urandom);
            end
            u = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n;
            run_packet($sformatf("rnd%0d", r), n, u, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
